// File: rtl/counter_pkg.sv
// Shared types and helpers for the up/down modulo counter family.
// Holds direction/mode encodings and the load clamp used by every instance.
package counter_pkg;

  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_e;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Widest legal count is 32 bits and MODULO may reach 2**32, so 33 bits.
  function automatic logic [32:0] clamp_load(
    input logic [32:0] val,
    input logic [32:0] modulo
  );
    return (val < modulo) ? val : modulo - 33'd1;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Clock-enable divider for updown_mod_counter.
// strobe is high on the enabled cycle where pre_cnt reaches PRESCALE-1.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic strobe
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_cnt;

  assign strobe = en && (pre_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (clr) begin
      pre_cnt <= '0;
    end else if (en) begin
      pre_cnt <= (pre_cnt == LAST) ? '0 : pre_cnt + PW'(1);
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with load, clear, wrap/saturate and tc.
// Define UPDOWN_COUNTER_PRESCALE_EN to gate stepping through counter_prescaler.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int     WIDTH    = 4,
  parameter longint MODULO   = 16,
  parameter int     SATURATE = 0,
  parameter int     PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULO - 1);
  localparam bit SAT = (SATURATE == MODE_SAT);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("updown_mod_counter: WIDTH must be 1..32");
  end
  if (MODULO < 2 || MODULO > (longint'(1) << WIDTH)) begin : g_bad_mod
    $error("updown_mod_counter: MODULO must be 2..2**WIDTH");
  end
  if (PRESCALE < 2) begin : g_bad_pre
    $error("updown_mod_counter: PRESCALE must be >= 2");
  end

  dir_e dir;
  logic step;
  logic at_bound;
  logic held_up;
  logic held_dn;

  assign dir = dir_e'(up_dn);

`ifdef UPDOWN_COUNTER_PRESCALE_EN
  logic strobe;

  counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_pre (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clr   (clr | load),
    .strobe(strobe)
  );

  assign step = strobe;
`else
  assign step = en;
`endif

  assign at_bound = (dir == DIR_UP) ? (count == TOP)
                                    : (count == '0);
  assign tc = step && at_bound;

  // held_* remember a saturated hold so a parked counter pulses wrap once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      wrap    <= 1'b0;
      held_up <= 1'b0;
      held_dn <= 1'b0;
    end else if (clr) begin
      count   <= '0;
      wrap    <= 1'b0;
      held_up <= 1'b0;
      held_dn <= 1'b0;
    end else if (load) begin
      count   <= WIDTH'(clamp_load(33'(load_val),
                                   33'(MODULO)));
      wrap    <= 1'b0;
      held_up <= 1'b0;
      held_dn <= 1'b0;
    end else if (step) begin
      if (!at_bound) begin
        count   <= (dir == DIR_UP) ? count + WIDTH'(1)
                                   : count - WIDTH'(1);
        wrap    <= 1'b0;
        held_up <= 1'b0;
        held_dn <= 1'b0;
      end else if (!SAT) begin
        count   <= (dir == DIR_UP) ? '0 : TOP;
        wrap    <= 1'b1;
        held_up <= 1'b0;
        held_dn <= 1'b0;
      end else begin
        wrap    <= (dir == DIR_UP) ? !held_up : !held_dn;
        held_up <= (dir == DIR_UP);
        held_dn <= (dir == DIR_DN);
      end
    end else begin
      wrap <= 1'b0;
      if (!en) begin
        held_up <= 1'b0;
        held_dn <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench: three counter configurations on shared stimulus,
// checked every cycle against an arithmetic model plus literal directed cases.
module tb_updown_mod_counter;

  localparam int PRESCALE = 4;
`ifdef UPDOWN_COUNTER_PRESCALE_EN
  localparam bit PRE_ON = 1'b1;
`else
  localparam bit PRE_ON = 1'b0;
`endif
  localparam int MODS [3] = '{10, 10, 16};
  localparam int SATS [3] = '{0, 1, 0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] cnt [3];
  logic       wr [3];
  logic       tcv [3];

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  go = 1'b0;
  int  mc [3];
  int  mw [3];
  int  last [3];
  int  pre = 0;
  bit  stp;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(4), .MODULO(10), .SATURATE(0),
                       .PRESCALE(PRESCALE)) u_a (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr),
    .load(load), .load_val(load_val),
    .count(cnt[0]), .tc(tcv[0]), .wrap(wr[0]));

  updown_mod_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1),
                       .PRESCALE(PRESCALE)) u_b (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr),
    .load(load), .load_val(load_val),
    .count(cnt[1]), .tc(tcv[1]), .wrap(wr[1]));

  updown_mod_counter #(.WIDTH(4), .MODULO(16), .SATURATE(0),
                       .PRESCALE(PRESCALE)) u_c (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr),
    .load(load), .load_val(load_val),
    .count(cnt[2]), .tc(tcv[2]), .wrap(wr[2]));

  task automatic check(input string nm, input int i,
                       input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s[%0d] at %0t: got %0d expected %0d",
               nm, i, $time, act, exp);
    end
  endtask

  function automatic int model_tc(input int i);
    bit s;
    s = en && (!PRE_ON || pre == PRESCALE - 1);
    return (s && ((up_dn && mc[i] == MODS[i] - 1) ||
                  (!up_dn && mc[i] == 0))) ? 1 : 0;
  endfunction

  // last: 0 = no saturated hold on the previous edge, 1 = up, 2 = down
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        mc[i] = 0; mw[i] = 0; last[i] = 0;
      end
      pre = 0;
    end else begin
      stp = en && (!PRE_ON || pre == PRESCALE - 1);
      for (int i = 0; i < 3; i++) begin
        if (clr) begin
          mc[i] = 0; mw[i] = 0; last[i] = 0;
        end else if (load) begin
          mc[i] = (int'(load_val) < MODS[i]) ? int'(load_val)
                                              : MODS[i] - 1;
          mw[i] = 0; last[i] = 0;
        end else if (stp && up_dn) begin
          if (mc[i] < MODS[i] - 1) begin
            mc[i]++; mw[i] = 0; last[i] = 0;
          end else if (SATS[i] == 1) begin
            mw[i] = (last[i] != 1) ? 1 : 0; last[i] = 1;
          end else begin
            mc[i] = 0; mw[i] = 1; last[i] = 0;
          end
        end else if (stp) begin
          if (mc[i] > 0) begin
            mc[i]--; mw[i] = 0; last[i] = 0;
          end else if (SATS[i] == 1) begin
            mw[i] = (last[i] != 2) ? 1 : 0; last[i] = 2;
          end else begin
            mc[i] = MODS[i] - 1; mw[i] = 1; last[i] = 0;
          end
        end else begin
          mw[i] = 0;
          if (!en) last[i] = 0;
        end
      end
      if (clr || load) pre = 0;
      else if (en) pre = (pre == PRESCALE - 1) ? 0 : pre + 1;
    end
  end

  always @(negedge clk) begin
    if (go) begin
      for (int i = 0; i < 3; i++) begin
        check("count", i, int'(cnt[i]), mc[i]);
        check("wrap", i, int'(wr[i]), mw[i]);
        check("tc", i, int'(tcv[i]), model_tc(i));
      end
    end
  end

  task automatic drive(input bit e, input bit u, input bit c,
                       input bit l, input logic [3:0] v);
    en = e; up_dn = u; clr = c; load = l; load_val = v;
    @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check("rst_count", 0, int'(cnt[0]), 0);
    check("rst_wrap", 0, int'(wr[0]), 0);
    check("rst_tc", 0, int'(tcv[0]), 0);
    rst = 1'b0;
    go = 1'b1;

`ifndef UPDOWN_COUNTER_PRESCALE_EN
    for (int k = 1; k <= 15; k++) begin
      drive(1, 1, 0, 0, 4'd0);
      check("t1_count", 0, int'(cnt[0]), k % 10);
      check("t1_wrap", 0, int'(wr[0]), (k == 10) ? 1 : 0);
      check("t1_tc", 0, int'(tcv[0]), (k == 9) ? 1 : 0);
      check("t3_count", 1, int'(cnt[1]), (k < 9) ? k : 9);
      check("t3_wrap", 1, int'(wr[1]), (k == 10) ? 1 : 0);
      check("t1_count", 2, int'(cnt[2]), k);
      check("t1_tc", 2, int'(tcv[2]), (k == 15) ? 1 : 0);
    end
    drive(1, 0, 0, 0, 4'd0);
    check("t3_dn", 0, int'(cnt[0]), 4);
    check("t3_dn", 1, int'(cnt[1]), 8);
    check("t3_dn", 2, int'(cnt[2]), 14);

    drive(1, 1, 1, 0, 4'd0);
    en = 1'b1; up_dn = 1'b0; clr = 1'b0;
    #1;
    check("t2_tc0", 0, int'(tcv[0]), 1);
    for (int k = 1; k <= 3; k++) begin
      drive(1, 0, 0, 0, 4'd0);
      check("t2_count", 0, int'(cnt[0]), 10 - k);
      check("t2_wrap", 0, int'(wr[0]), (k == 1) ? 1 : 0);
      check("t2_count", 2, int'(cnt[2]), 16 - k);
      check("t2_sat", 1, int'(cnt[1]), 0);
      check("t2_satwrap", 1, int'(wr[1]), (k == 1) ? 1 : 0);
    end
`else
    for (int k = 1; k <= 8; k++) begin
      drive(1, 1, 0, 0, 4'd0);
      check("p_count", 0, int'(cnt[0]), k / 4);
    end
    drive(1, 1, 0, 0, 4'd0);
    drive(1, 1, 0, 0, 4'd0);
    repeat (3) drive(0, 1, 0, 0, 4'd0);
    drive(1, 1, 0, 0, 4'd0);
    check("p_pause", 0, int'(cnt[0]), 2);
    drive(1, 1, 0, 0, 4'd0);
    check("p_resume", 0, int'(cnt[0]), 3);
    drive(0, 1, 0, 1, 4'd9);
    en = 1'b1; up_dn = 1'b1; load = 1'b0;
    #1;
    check("p_tc_nostrobe", 0, int'(tcv[0]), 0);
    repeat (3) drive(1, 1, 0, 0, 4'd0);
    check("p_tc_strobe", 0, int'(tcv[0]), 1);
    drive(1, 1, 0, 0, 4'd0);
    check("p_wrapcnt", 0, int'(cnt[0]), 0);
    check("p_wrap", 0, int'(wr[0]), 1);
`endif

    drive(0, 1, 0, 1, 4'd7);
    check("t4_load7", 0, int'(cnt[0]), 7);
    drive(0, 1, 0, 1, 4'd13);
    check("t4_clamp", 0, int'(cnt[0]), 9);
    check("t4_clamp", 1, int'(cnt[1]), 9);
    check("t4_noclamp", 2, int'(cnt[2]), 13);
    drive(1, 1, 1, 1, 4'd5);
    check("t4_clrload", 0, int'(cnt[0]), 0);

`ifndef UPDOWN_COUNTER_PRESCALE_EN
    repeat (5) drive(1, 1, 0, 0, 4'd0);
    check("t5_pre", 0, int'(cnt[0]), 5);
    rst = 1'b1;
    #1;
    check("t5_async", 0, int'(cnt[0]), 0);
    #1;
    rst = 1'b0;
    drive(1, 1, 0, 0, 4'd0);
    check("t5_resume", 0, int'(cnt[0]), 1);
    repeat (9) drive(1, 1, 0, 0, 4'd0);
    check("t5_wrap", 0, int'(wr[0]), 1);
    rst = 1'b1;
    #1;
    check("t5_drop", 0, int'(wr[0]), 0);
    #1;
    rst = 1'b0;
`endif

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 3) != 0,
            ($urandom_range(0, 9) == 0) ? !up_dn : up_dn,
            $urandom_range(0, 32) == 0,
            $urandom_range(0, 19) == 0,
            4'($urandom_range(0, 15)));
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
- Parametrised successor to the team's 4-bit free-running up counter.
- Adds configurable width and modulus, direction control, count enable, synchronous clear and parallel load, wrap or saturate mode, and terminal-count/wrap flags.
- Used as a general timebase, event counter and BCD/decade stage across the design; instances cascade through tc.

Parameters:
- WIDTH, 4, count register width in bits (1..32).
- MODULO, 16, count range 0..MODULO-1; legal range 2..2**WIDTH.
- SATURATE, 0, 0 = wrap at bounds, 1 = hold at bounds.
- PRESCALE, 4, clock-enable divide ratio (2..256); used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable.
- up_dn  in  1  1 = count up, 0 = count down; sampled each cycle.
- clr  in  1  synchronous clear to 0.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value to load.
- count  out  WIDTH  current count, registered.
- tc  out  1  combinational terminal count: en && count at bound in current direction.
- wrap  out  1  registered one-cycle pulse, the cycle after count wrapped or hit saturation.

Behaviour:
- Reset: rst=1 forces count=0 and wrap=0 immediately, with no clock; the prescaler also clears. tc then follows its equation.
- Per-edge priority: clr > load > (en && step) > hold.
- clr: count<=0; wrap<=0.
- load:
  - count<=load_val if load_val < MODULO, else count<=MODULO-1 (clamped).
  - wrap<=0.
- Step up:
  - count < MODULO-1: count+1.
  - count == MODULO-1: wrap mode gives 0 with wrap<=1; saturate mode holds MODULO-1 with wrap<=1 only on the first arrival.
- Step down:
  - count > 0: count-1.
  - count == 0: wrap mode gives MODULO-1 with wrap<=1; saturate mode holds 0 with wrap<=1 only on the first arrival.
- "First arrival" means the previous edge was not also a saturated hold in the same direction; a saturated counter left enabled produces a single wrap pulse.
- tc = en && ((up_dn && count==MODULO-1) || (!up_dn && count==0)).
  - Usable as the next stage's en for cascading.
  - Zero latency from en/up_dn; one cycle ahead of the wrap pulse.
- wrap is 0 on every edge not listed above.
- Arithmetic:
  - The increment/decrement wraps naturally in WIDTH bits when MODULO==2**WIDTH.
  - All comparisons are unsigned.
  - No intermediate may exceed WIDTH+1 bits.
- Direction change mid-count takes effect on the next edge, with no lost or extra step.
- Async reset mid-operation: a pending wrap pulse is dropped; counting resumes from 0 on the first edge after deassertion.
- Elaboration error (generate-time $error) if MODULO > 2**WIDTH, MODULO < 2, or PRESCALE < 2.

Optional Feature:
- Macro: UPDOWN_COUNTER_PRESCALE_EN.
- Defined:
  - An internal prescaler produces step = en && (pre_cnt == PRESCALE-1); pre_cnt advances only while en=1.
  - clr and load also zero pre_cnt.
  - tc additionally ANDs the prescaler strobe, so cascades stay aligned.
- Undefined: step = en; no prescaler logic is present and the PRESCALE parameter is ignored.

Decomposition:
- Shared package counter_pkg holds:
  - enum dir_e {DIR_DN=0, DIR_UP=1}
  - mode constants MODE_WRAP=0, MODE_SAT=1
  - function clamp_load(val, modulo)
- One sub-module: counter_prescaler (PRESCALE param; ports clk, rst, en, clr, strobe), instantiated only under UPDOWN_COUNTER_PRESCALE_EN.

Test Plan:
1. WIDTH=4, MODULO=10, wrap mode, en=1, up_dn=1, 12 edges from reset → count 1..9,0,1,2; tc=1 only while count==9; wrap=1 exactly one cycle, the cycle when count==0.
2. Same configuration, up_dn=0 from count=0 → count 9,8,...; wrap pulses after the 0→9 step; tc=1 while count==0.
3. SATURATE=1, MODULO=10, en=1 up for 15 edges → count sticks at 9; wrap pulses once only; switching up_dn=0 gives count 8 on the next edge.
4. load=1 with load_val=7, then load=1 with load_val=13, with MODULO=10 → count=7, then count=9 (clamped); clr and load together → count=0.
5. Assert rst asynchronously mid-cycle at count=5 → count=0 before the next clk edge; en held, so the first edge after release gives count=1.
6. UPDOWN_COUNTER_PRESCALE_EN defined, PRESCALE=4, en=1 up → count increments every 4th edge; tc only on the strobe cycle when count==MODULO-1; toggling en pauses pre_cnt.
